// File: rtl/systolic_array_param.sv
// Output-stationary ROWS x COLS MAC systolic array with input skewing, a
// start/feed/flush/drain controller and a row-serial result drain.
module systolic_array_param #(
  parameter int DATA_SIZE = 8,
  parameter int ACC_SIZE  = 32,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [K_W-1:0]                k_len,
  input  logic                          is_signed,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_SIZE-1:0]     a_vec,
  input  logic [COLS*DATA_SIZE-1:0]     b_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*ACC_SIZE-1:0]      out_row,
  output logic [$clog2(ROWS)-1:0]       out_row_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = $clog2(ROWS);
  localparam int FC_W  = $clog2(ROWS + COLS);
  localparam int PW    = 2 * DATA_SIZE + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                 state_r, next_state_s;
  logic [K_W-1:0]         k_len_r, beat_cnt_r;
  logic                   is_signed_r;
  logic [FC_W-1:0]        flush_cnt_r;
  logic                   accept_start_s, beat_s, advance_s, last_beat_s, flush_end_s;
  logic                   row_accept_s, last_row_s;

  logic                   in_ready_r, out_valid_r, busy_r, done_r;
  logic [COLS*ACC_SIZE-1:0] out_row_r, row_pack_s;
  logic [IDX_W-1:0]       out_row_idx_r, row_sel_s;

  logic [DATA_SIZE-1:0]   skew_a_r [ROWS][ROWS];
  logic [DATA_SIZE-1:0]   skew_b_r [COLS][COLS];
  logic [DATA_SIZE-1:0]   a_in_s   [ROWS][COLS];
  logic [DATA_SIZE-1:0]   b_in_s   [ROWS][COLS];
  logic [DATA_SIZE-1:0]   a_fwd_r  [ROWS][COLS-1];
  logic [DATA_SIZE-1:0]   b_fwd_r  [ROWS-1][COLS];
  logic [ACC_SIZE-1:0]    acc_r    [ROWS][COLS];

  // Exact (DATA_SIZE+1)-bit signed product, then sign-extended or wrapped to ACC_SIZE.
  function automatic logic [ACC_SIZE-1:0] mac_product(
    input logic [DATA_SIZE-1:0] a,
    input logic [DATA_SIZE-1:0] b,
    input logic                 sgn
  );
    logic signed [DATA_SIZE:0] a_e;
    logic signed [DATA_SIZE:0] b_e;
    logic signed [PW-1:0]      p;
    a_e = $signed({sgn & a[DATA_SIZE-1], a});
    b_e = $signed({sgn & b[DATA_SIZE-1], b});
    p   = PW'(a_e) * PW'(b_e);
    return ACC_SIZE'(p);
  endfunction

  // A start coinciding with the done pulse is deliberately not accepted.
  assign accept_start_s = (state_r == IDLE) && start && !done_r;
  assign beat_s         = (state_r == FEED) && in_valid;
  assign last_beat_s    = beat_s && (beat_cnt_r == (k_len_r - K_W'(1)));
  assign flush_end_s    = (state_r == FLUSH) && (flush_cnt_r == FC_W'(ROWS + COLS - 2));
  assign advance_s      = (state_r == FEED) || (state_r == FLUSH);
  assign row_accept_s   = (state_r == DRAIN) && out_valid_r && out_ready;
  assign last_row_s     = row_accept_s && (out_row_idx_r == IDX_W'(ROWS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_start_s) begin
          if (k_len == {K_W{1'b0}}) next_state_s = DRAIN;
          else                      next_state_s = FEED;
        end else begin
          next_state_s = IDLE;
        end
      end
      FEED: begin
        if (last_beat_s) next_state_s = FLUSH;
        else             next_state_s = FEED;
      end
      FLUSH: begin
        if (flush_end_s) next_state_s = DRAIN;
        else             next_state_s = FLUSH;
      end
      DRAIN: begin
        if (last_row_s) next_state_s = IDLE;
        else            next_state_s = DRAIN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Tile configuration latch plus beat and flush counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_r     <= {K_W{1'b0}};
      is_signed_r <= 1'b0;
      beat_cnt_r  <= {K_W{1'b0}};
      flush_cnt_r <= {FC_W{1'b0}};
    end else begin
      if (accept_start_s) begin
        k_len_r     <= k_len;
        is_signed_r <= is_signed;
        beat_cnt_r  <= {K_W{1'b0}};
      end else if (beat_s) begin
        beat_cnt_r  <= beat_cnt_r + K_W'(1);
      end
      if (state_r == FLUSH) flush_cnt_r <= flush_cnt_r + FC_W'(1);
      else                  flush_cnt_r <= {FC_W{1'b0}};
    end
  end

  // Skew delay lines; stage 0 captures the beat (or zero on a bubble), lane i reads stage i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int s = 0; s < ROWS; s++) skew_a_r[i][s] <= {DATA_SIZE{1'b0}};
      for (int j = 0; j < COLS; j++)
        for (int s = 0; s < COLS; s++) skew_b_r[j][s] <= {DATA_SIZE{1'b0}};
    end else if (accept_start_s) begin
      for (int i = 0; i < ROWS; i++)
        for (int s = 0; s < ROWS; s++) skew_a_r[i][s] <= {DATA_SIZE{1'b0}};
      for (int j = 0; j < COLS; j++)
        for (int s = 0; s < COLS; s++) skew_b_r[j][s] <= {DATA_SIZE{1'b0}};
    end else if (advance_s) begin
      for (int i = 0; i < ROWS; i++) begin
        skew_a_r[i][0] <= beat_s ? a_vec[i*DATA_SIZE +: DATA_SIZE] : {DATA_SIZE{1'b0}};
        for (int s = 1; s < ROWS; s++) skew_a_r[i][s] <= skew_a_r[i][s-1];
      end
      for (int j = 0; j < COLS; j++) begin
        skew_b_r[j][0] <= beat_s ? b_vec[j*DATA_SIZE +: DATA_SIZE] : {DATA_SIZE{1'b0}};
        for (int s = 1; s < COLS; s++) skew_b_r[j][s] <= skew_b_r[j][s-1];
      end
    end
  end

  // PE operand selection: edge PEs read the skew lines, inner PEs their neighbours.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_in_s[i][0] = skew_a_r[i][i];
      for (int j = 1; j < COLS; j++) a_in_s[i][j] = a_fwd_r[i][j-1];
    end
    for (int j = 0; j < COLS; j++) begin
      b_in_s[0][j] = skew_b_r[j][j];
      for (int i = 1; i < ROWS; i++) b_in_s[i][j] = b_fwd_r[i-1][j];
    end
  end

  // PE grid: accumulate and forward operands right/down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_r[i][j] <= {ACC_SIZE{1'b0}};
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS - 1; j++) a_fwd_r[i][j] <= {DATA_SIZE{1'b0}};
      for (int i = 0; i < ROWS - 1; i++)
        for (int j = 0; j < COLS; j++) b_fwd_r[i][j] <= {DATA_SIZE{1'b0}};
    end else if (accept_start_s) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_r[i][j] <= {ACC_SIZE{1'b0}};
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS - 1; j++) a_fwd_r[i][j] <= {DATA_SIZE{1'b0}};
      for (int i = 0; i < ROWS - 1; i++)
        for (int j = 0; j < COLS; j++) b_fwd_r[i][j] <= {DATA_SIZE{1'b0}};
    end else if (advance_s) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_r[i][j] <= acc_r[i][j] + mac_product(a_in_s[i][j], b_in_s[i][j], is_signed_r);
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS - 1; j++) a_fwd_r[i][j] <= a_in_s[i][j];
      for (int i = 0; i < ROWS - 1; i++)
        for (int j = 0; j < COLS; j++) b_fwd_r[i][j] <= b_in_s[i][j];
    end
  end

  // Row to load next: the current index on the first drain cycle, else the following one.
  always_comb begin
    row_sel_s  = out_row_idx_r;
    row_pack_s = {(COLS*ACC_SIZE){1'b0}};
    if (out_valid_r && (out_row_idx_r != IDX_W'(ROWS - 1))) begin
      row_sel_s = out_row_idx_r + IDX_W'(1);
    end else begin
      row_sel_s = out_row_idx_r;
    end
    for (int j = 0; j < COLS; j++) row_pack_s[j*ACC_SIZE +: ACC_SIZE] = acc_r[row_sel_s][j];
  end

  // Registered handshake/status outputs and the drain row register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      out_valid_r   <= 1'b0;
      out_row_r     <= {(COLS*ACC_SIZE){1'b0}};
      out_row_idx_r <= {IDX_W{1'b0}};
    end else begin
      in_ready_r <= (next_state_s == FEED);
      busy_r     <= (next_state_s != IDLE);
      done_r     <= 1'b0;
      if (state_r == DRAIN) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          out_row_r   <= row_pack_s;
        end else if (out_ready) begin
          if (out_row_idx_r == IDX_W'(ROWS - 1)) begin
            out_valid_r   <= 1'b0;
            out_row_r     <= {(COLS*ACC_SIZE){1'b0}};
            out_row_idx_r <= {IDX_W{1'b0}};
            done_r        <= 1'b1;
          end else begin
            out_row_idx_r <= out_row_idx_r + IDX_W'(1);
            out_row_r     <= row_pack_s;
          end
        end
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign out_valid   = out_valid_r;
  assign out_row     = out_row_r;
  assign out_row_idx = out_row_idx_r;

endmodule

// File: doc/systolic_array_param.md
Name: systolic_array_param

Overview:
- Parametrised output-stationary ROWS x COLS multiply-accumulate systolic array. Successor to the fixed 4x4 8-bit array.
- Adds internal input skewing, a start/feed/flush/drain controller, a valid/ready input stream, signed/unsigned mode, configurable accumulator width, and row-serial result drain with backpressure.
- Sits between the operand buffers (A rows, B columns) and the result writeback path of the TPU datapath.

Parameters:
- DATA_SIZE, 8, operand width in bits.
- ACC_SIZE, 32, accumulator/result width; must be >= 2*DATA_SIZE.
- ROWS, 4, PE rows (A lanes); >= 2.
- COLS, 4, PE columns (B lanes); >= 2.
- K_W, 16, width of the inner-dimension length field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a tile when state is IDLE.
- k_len  in  K_W  inner-dimension beat count, sampled on accepted start.
- is_signed  in  1  1 = two's-complement operands; sampled on accepted start.
- in_valid  in  1  a_vec/b_vec beat valid.
- in_ready  out  1  high only in FEED.
- a_vec  in  ROWS*DATA_SIZE  A column k, unskewed; lane i = bits [i*DATA_SIZE +: DATA_SIZE].
- b_vec  in  COLS*DATA_SIZE  B row k, unskewed; same lane packing.
- out_valid  out  1  result row available (DRAIN only).
- out_ready  in  1  consumer accepts row.
- out_row  out  COLS*ACC_SIZE  C[out_row_idx][0..COLS-1]; lane j = bits [j*ACC_SIZE +: ACC_SIZE].
- out_row_idx  out  $clog2(ROWS)  row index of out_row.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All accumulators, skew registers, PE pipeline registers and counters cleared. Outputs: in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0. Reset during any state aborts the tile; no done pulse is produced.
- PE(i,j):
  - Each cycle in FEED/FLUSH: acc += ext(a)*ext(b); forward a right and b down, each through one register.
  - ext = sign-extend if the latched is_signed=1, else zero-extend.
  - The product is 2*DATA_SIZE wide and is sign/zero-extended to ACC_SIZE.
  - Accumulation wraps modulo 2^ACC_SIZE; there is no saturation.
- Skew: lane i of a_vec is delayed i cycles before entering row i; lane j of b_vec is delayed j cycles before entering column j. The array advances every cycle in FEED and FLUSH. Cycles with no accepted beat inject zeros, so bubbles do not corrupt results.
- FSM:
  - IDLE:
    - start=1 latches k_len and is_signed and clears accumulators and skew registers.
    - Goes to FEED if k_len != 0.
    - If k_len == 0, goes straight to DRAIN and all results are 0.
  - FEED:
    - in_ready=1; each in_valid & in_ready cycle is one beat; the beat counter increments.
    - After the k_len-th beat, goes to FLUSH next cycle.
    - in_valid while not in FEED is ignored.
  - FLUSH:
    - Exactly ROWS+COLS-1 cycles of zero injection, then DRAIN.
  - DRAIN:
    - out_valid=1; out_row = accumulators of row out_row_idx, starting at 0.
    - On out_valid & out_ready, out_row_idx increments.
    - On acceptance of row ROWS-1: go to IDLE, pulse done=1 for one cycle, clear out_row_idx to 0.
    - While out_ready=0, out_row and out_row_idx hold stable.
- start outside IDLE is ignored, including start coincident with the done cycle; start is accepted in IDLE on the following cycle.
- Latency, no bubbles, start accepted at edge 0:
  - Beats occur at edges 1..k_len.
  - First out_valid is asserted after edge k_len+ROWS+COLS.
  - With out_ready held at 1, done follows ROWS cycles later.
- Accumulators hold their values after DRAIN until the next accepted start.

Test Plan:
- Identity, ROWS=COLS=4, unsigned, k_len=4: A = I, B[k][j] = 4k+j+1 -> out rows 0..3 = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; first out_valid after edge 12; done pulses once.
- Signed, k_len=2: all A = -3 (0xFD), all B = 5 -> every result is -30 (0xFFFFFFE2). The same data with is_signed=0 gives 253*5*2 = 2530.
- Bubbles and backpressure, k_len=4 with in_valid toggling 1,0,1,0,... and out_ready low for 3 cycles per row -> results identical to the first test; out_row stable while stalled.
- Overflow wrap, ACC_SIZE=16, unsigned, k_len=2, all operands 255 -> 2*65025 mod 65536 = 64514 in every lane.
- k_len=0 -> DRAIN immediately after start, all rows 0, done pulses. A start asserted during DRAIN is ignored (no restart; row sequence unchanged).
- rst asserted mid-FEED (after 2 of 4 beats) -> all outputs 0 and busy=0 immediately. A new full tile afterwards produces the correct results with no stale partial sums.
